// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Round-robin, per-message arbiter that shares one uart_tx byte serializer
// between NUM_REQ byte-stream requesters, with a one-entry output register.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   req_val_i  per-requester byte valid
//   req_dat_i  per-requester byte, requester k at [k*DATA_WD +: DATA_WD]
//   req_lst_i  per-requester last-byte-of-message flag
//   req_ack_o  per-requester byte accept (combinational)
//   val_o      byte valid toward uart_tx
//   dat_o      byte toward uart_tx
//   ready_i    uart_tx ready; transfer on val_o && ready_i
//   gnt_idx_o  current or most recent grant holder
//   busy_o     LOCK state or output register occupied
//   err_o      one-cycle pulse after a forced (length guard) release
module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_WD  = 2,
  parameter int DATA_WD = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_val_i,
  input  logic [NUM_REQ*DATA_WD-1:0] req_dat_i,
  input  logic [NUM_REQ-1:0]         req_lst_i,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic                       val_o,
  output logic [DATA_WD-1:0]         dat_o,
  input  logic                       ready_i,
  output logic [IDX_WD-1:0]          gnt_idx_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int LEN_WD = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_WD-1:0]    r_ptr;
  logic [IDX_WD-1:0]    r_gnt;
  logic [LEN_WD-1:0]    r_len;
  logic                 r_val;
  logic [DATA_WD-1:0]   r_dat;
  logic                 r_err;

  logic [IDX_WD-1:0]    w_pick;
  logic                 w_found;
  logic [IDX_WD-1:0]    w_idx;
  logic                 w_hit;
  logic [DATA_WD-1:0]   w_gnt_dat;
  logic                 w_gnt_val;
  logic                 w_gnt_lst;
  logic                 w_len_max;
  logic                 w_ack;
  logic                 w_rel;
  logic                 w_force;

  // Round-robin search: first valid requester upward from ptr+1, wrapping.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_hit   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx   = IDX_WD'((int'(r_ptr) + i) % NUM_REQ);
      w_hit   = !w_found && req_val_i[w_idx];
      w_pick  = w_hit ? w_idx : w_pick;
      w_found = w_found || w_hit;
    end
  end

  // Select the granted requester's byte, valid and last flag.
  always_comb begin
    w_gnt_dat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_gnt_dat = (r_gnt == IDX_WD'(k)) ? req_dat_i[k*DATA_WD +: DATA_WD] : w_gnt_dat;
    end
    w_gnt_val = req_val_i[r_gnt];
    w_gnt_lst = req_lst_i[r_gnt];
    w_len_max = (r_len == LEN_WD'(MAX_LEN - 1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_found ? ST_LOCK : ST_IDLE;
      ST_LOCK: w_state_nxt = w_rel ? ST_IDLE : ST_LOCK;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: ack only in LOCK, when the output register can take a byte
  // (empty, or draining this same cycle).
  always_comb begin
    w_ack     = 1'b0;
    w_rel     = 1'b0;
    w_force   = 1'b0;
    req_ack_o = '0;
    case (r_state)
      ST_LOCK: begin
        w_ack     = w_gnt_val && (!r_val || ready_i);
        w_rel     = w_ack && (w_gnt_lst || w_len_max);
        w_force   = w_ack && !w_gnt_lst && w_len_max;
        req_ack_o = w_ack ? (NUM_REQ'(1) << r_gnt) : '0;
      end
      ST_IDLE: begin
        w_ack     = 1'b0;
        w_rel     = 1'b0;
        w_force   = 1'b0;
        req_ack_o = '0;
      end
      default: begin
        w_ack     = 1'b0;
        w_rel     = 1'b0;
        w_force   = 1'b0;
        req_ack_o = '0;
      end
    endcase
  end

  // Grant, pointer, length counter, output register and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IDX_WD'(NUM_REQ - 1);
      r_gnt <= '0;
      r_len <= '0;
      r_val <= 1'b0;
      r_dat <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_force;
      if ((r_state == ST_IDLE) && w_found) begin
        r_gnt <= w_pick;
        r_len <= '0;
      end else if (w_ack && !w_rel) begin
        r_len <= r_len + LEN_WD'(1);
      end
      if (w_rel) begin
        r_ptr <= r_gnt;
      end
      // A new byte overrides a same-cycle drain so val_o stays high.
      if (w_ack) begin
        r_val <= 1'b1;
        r_dat <= w_gnt_dat;
      end else if (r_val && ready_i) begin
        r_val <= 1'b0;
      end
    end
  end

  assign val_o     = r_val;
  assign dat_o     = r_dat;
  assign gnt_idx_o = r_gnt;
  assign err_o     = r_err;
  assign busy_o    = (r_state == ST_LOCK) || r_val;

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_val;
  logic [31:0] req_dat;
  logic [3:0]  req_lst;
  logic [3:0]  req_ack;
  logic        val_o;
  logic [7:0]  dat_o;
  logic        ready;
  logic [1:0]  gnt;
  logic        busy;
  logic        err;

  uart_tx_arb #(.NUM_REQ(4), .IDX_WD(2), .DATA_WD(8), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .req_val_i(req_val), .req_dat_i(req_dat),
    .req_lst_i(req_lst), .req_ack_o(req_ack), .val_o(val_o), .dat_o(dat_o),
    .ready_i(ready), .gnt_idx_o(gnt), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Requester model: {lst, byte} per entry.
  logic [8:0] src_q [4][$];
  logic [3:0] en;
  logic       rdy_toggle;
  int         phase;

  int         ack_log[$];
  int         ack_cyc[$];
  logic [7:0] out_log[$];
  int         err_cnt;
  int         err_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer / ack / error log; cleared while reset is asserted.
  always @(negedge clk) begin
    if (rst) begin
      ack_log.delete();
      ack_cyc.delete();
      out_log.delete();
      err_cnt = 0;
      err_cyc = -1;
    end else begin
      if (val_o && ready) out_log.push_back(dat_o);
      for (int k = 0; k < 4; k++) begin
        if (req_ack[k]) begin
          ack_log.push_back(k);
          ack_cyc.push_back(cyc);
        end
      end
      if (err) begin
        err_cnt = err_cnt + 1;
        err_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_val = 4'b0;
    req_dat = 32'h0;
    req_lst = 4'b0;
    ready = 1'b1;
    en = 4'b1111;
    rdy_toggle = 1'b0;
    phase = 0;
    for (int k = 0; k < 4; k++) src_q[k].delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drives the requester model for n cycles; pops a byte on each ack.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (src_q[k].size() > 0 && en[k]) begin
          req_val[k] = 1'b1;
          req_dat[k*8 +: 8] = src_q[k][0][7:0];
          req_lst[k] = src_q[k][0][8];
        end else begin
          req_val[k] = 1'b0;
          req_dat[k*8 +: 8] = 8'h00;
          req_lst[k] = 1'b0;
        end
      end
      ready = rdy_toggle ? (phase != 0) : 1'b1;
      phase = (phase + 1) % 4;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (req_ack[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (val_o !== 1'b0) begin errors++; $display("FAIL reset_val: got %0h expected 0", val_o); end
    checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat: got %0h expected 0", dat_o); end
    checks++; if (gnt !== 2'd0) begin errors++; $display("FAIL reset_gnt: got %0h expected 0", gnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h expected 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %0h expected 0", req_ack); end
  endtask

  task automatic test_basic();
    do_reset();
    req_val = 4'b0100; req_dat[23:16] = 8'h41; req_lst = 4'b0000; ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL basic_idle_ack: got %0h expected 0", req_ack); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (gnt !== 2'd2) begin errors++; $display("FAIL basic_gnt: got %0h expected 2", gnt); end
    checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL basic_ack1: got %0h expected 4", req_ack); end
    @(posedge clk); #1; req_dat[23:16] = 8'h42;
    @(negedge clk);
    checks++; if (val_o !== 1'b1 || dat_o !== 8'h41) begin errors++; $display("FAIL basic_out1: got val %0h dat %0h expected 1/41", val_o, dat_o); end
    checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL basic_ack2: got %0h expected 4", req_ack); end
    @(posedge clk); #1; req_dat[23:16] = 8'h43; req_lst = 4'b0100;
    @(negedge clk);
    checks++; if (val_o !== 1'b1 || dat_o !== 8'h42) begin errors++; $display("FAIL basic_out2: got val %0h dat %0h expected 1/42", val_o, dat_o); end
    checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL basic_ack3: got %0h expected 4", req_ack); end
    @(posedge clk); #1; req_val = 4'b0000; req_lst = 4'b0000;
    @(negedge clk);
    checks++; if (val_o !== 1'b1 || dat_o !== 8'h43) begin errors++; $display("FAIL basic_out3: got val %0h dat %0h expected 1/43", val_o, dat_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy4: got %0h expected 1", busy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || val_o !== 1'b0) begin errors++; $display("FAIL basic_idle5: got busy %0h val %0h expected 0/0", busy, val_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 3; i++) src_q[k].push_back({1'b1, 8'(k * 16 + i)});
    run_cycles(40);
    checks++; if (ack_log.size() !== 12) begin errors++; $display("FAIL rr_count: got %0d expected 12", ack_log.size()); end
    for (int j = 0; j < 12 && j < ack_log.size(); j++) begin
      checks++; if (ack_log[j] !== j % 4) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", j, ack_log[j], j % 4); end
      checks++; if (out_log[j] !== 8'((j % 4) * 16 + j / 4)) begin errors++; $display("FAIL rr_byte[%0d]: got %0h expected %0h", j, out_log[j], 8'((j % 4) * 16 + j / 4)); end
      if (j > 0) begin
        checks++; if (ack_cyc[j] - ack_cyc[j-1] !== 2) begin errors++; $display("FAIL rr_gap[%0d]: got %0d expected 2", j, ack_cyc[j] - ack_cyc[j-1]); end
      end
    end
  endtask

  task automatic test_lock_backpressure();
    logic [7:0] exp_b [5];
    int exp_r [5];
    exp_b[0] = 8'h10; exp_b[1] = 8'h11; exp_b[2] = 8'h12; exp_b[3] = 8'h13; exp_b[4] = 8'h01;
    exp_r[0] = 1; exp_r[1] = 1; exp_r[2] = 1; exp_r[3] = 1; exp_r[4] = 0;
    do_reset();
    rdy_toggle = 1'b1;
    for (int i = 0; i < 4; i++) src_q[1].push_back({(i == 3) ? 1'b1 : 1'b0, 8'(8'h10 + i)});
    run_cycles(1);
    src_q[0].push_back({1'b1, 8'h01});
    run_cycles(40);
    checks++; if (ack_log.size() !== 5) begin errors++; $display("FAIL lock_ack_count: got %0d expected 5", ack_log.size()); end
    checks++; if (out_log.size() !== 5) begin errors++; $display("FAIL lock_out_count: got %0d expected 5", out_log.size()); end
    for (int j = 0; j < 5 && j < ack_log.size() && j < out_log.size(); j++) begin
      checks++; if (ack_log[j] !== exp_r[j]) begin errors++; $display("FAIL lock_order[%0d]: got %0d expected %0d", j, ack_log[j], exp_r[j]); end
      checks++; if (out_log[j] !== exp_b[j]) begin errors++; $display("FAIL lock_byte[%0d]: got %0h expected %0h", j, out_log[j], exp_b[j]); end
    end
  endtask

  task automatic test_forced_release();
    int er;
    logic [7:0] eb;
    do_reset();
    for (int i = 0; i < 20; i++) src_q[3].push_back({1'b0, 8'(8'h80 + i)});
    run_cycles(1);
    src_q[0].push_back({1'b1, 8'h01});
    run_cycles(40);
    checks++; if (ack_log.size() !== 21) begin errors++; $display("FAIL force_ack_count: got %0d expected 21", ack_log.size()); end
    checks++; if (out_log.size() !== 21) begin errors++; $display("FAIL force_out_count: got %0d expected 21", out_log.size()); end
    for (int j = 0; j < 21 && j < ack_log.size() && j < out_log.size(); j++) begin
      er = (j == 16) ? 0 : 3;
      eb = (j < 16) ? 8'(8'h80 + j) : ((j == 16) ? 8'h01 : 8'(8'h80 + j - 1));
      checks++; if (ack_log[j] !== er) begin errors++; $display("FAIL force_order[%0d]: got %0d expected %0d", j, ack_log[j], er); end
      checks++; if (out_log[j] !== eb) begin errors++; $display("FAIL force_byte[%0d]: got %0h expected %0h", j, out_log[j], eb); end
    end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL force_err_count: got %0d expected 1", err_cnt); end
    if (ack_cyc.size() > 16) begin
      checks++; if (err_cyc !== ack_cyc[15] + 1) begin errors++; $display("FAIL force_err_cycle: got %0d expected %0d", err_cyc, ack_cyc[15] + 1); end
      checks++; if (ack_cyc[16] !== ack_cyc[15] + 2) begin errors++; $display("FAIL force_regrant: got %0d expected %0d", ack_cyc[16], ack_cyc[15] + 2); end
    end else begin
      checks++; errors++; $display("FAIL force_err_cycle: got %0d acks expected at least 17", ack_cyc.size());
    end
  endtask

  task automatic test_drain_and_ack();
    do_reset();
    req_val = 4'b0010; req_dat[15:8] = 8'h55; req_lst = 4'b0000; ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL drain_first_ack: got %0h expected 2", req_ack); end
    @(posedge clk); #1; req_dat[15:8] = 8'hAA; ready = 1'b1;
    @(negedge clk);
    checks++; if (val_o !== 1'b1 || dat_o !== 8'h55) begin errors++; $display("FAIL drain_hold: got val %0h dat %0h expected 1/55", val_o, dat_o); end
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL drain_ack: got %0h expected 2", req_ack); end
    @(posedge clk); #1; req_val = 4'b0000; ready = 1'b0;
    @(negedge clk);
    checks++; if (val_o !== 1'b1 || dat_o !== 8'hAA) begin errors++; $display("FAIL drain_next: got val %0h dat %0h expected 1/aa", val_o, dat_o); end
    checks++; if (out_log.size() !== 1 || out_log[0] !== 8'h55) begin errors++; $display("FAIL drain_once: got %0d transfers expected one of 55", out_log.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_val = 4'b0100; req_dat[23:16] = 8'h66; req_lst = 4'b0000; ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; req_val = 4'b0101; req_dat[7:0] = 8'h01;
    @(negedge clk);
    checks++; if (val_o !== 1'b1) begin errors++; $display("FAIL rmid_pre_val: got %0h expected 1", val_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (val_o !== 1'b0) begin errors++; $display("FAIL rmid_val: got %0h expected 0", val_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: got busy %0h expected 0", busy); end
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL rmid_ack: got %0h expected 0", req_ack); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (gnt !== 2'd0) begin errors++; $display("FAIL rmid_gnt: got %0h expected 0", gnt); end
    checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL rmid_regrant_ack: got %0h expected 1", req_ack); end
    @(posedge clk); #1;
    req_val = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_lock_backpressure();
    test_forced_release();
    test_drain_and_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
